control_unit: RTL and testbench

//  Moore FSM that sequences the 8-bit CPU datapath through fetch, decode and execute.
//  It drives every datapath load, select and ALU control, plus the memory write strobe.
//  It reads the opcode from IR and the NZVC flags from CCR.
//  It sits between data_path and the memory system inside the CPU top level.

---
 rtl/control_unit.sv | 225 ++++++++++++++++++++++
 tb/tb_control_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit -- Moore sequencer for the 8-bit CPU datapath.
//
// Walks every instruction through FETCH_0/FETCH_1/FETCH_2/DECODE and then one
// execute path chosen from the opcode in IR.  The state register is the only
// storage.  Every output is decoded from the current state, plus IR where
// A/B or ADD/SUB share one path.  While Reset is high all outputs are zero,
// so an instruction aborted by reset cannot finish a write or a load.
//
// Ports
//   Clk, Reset        rising-edge clock, synchronous active-high reset
//   IR                opcode held in the datapath instruction register
//   CCR_Result        registered flags [3]=N [2]=Z [1]=V [0]=C
//   IR_Load .. B_Load register load strobes towards the datapath
//   PC_Inc            advance PC by one
//   CCR_Load          capture ALU flags
//   ALU_Sel           000 ADD, 010 SUB
//   Bus1_Sel          00 PC, 01 A, 10 B
//   Bus2_Sel          00 ALU, 01 Bus1, 10 from_memory
//   write             memory write strobe (data = Bus1, address = MAR)
//   halted            high while parked in HALT
module control_unit #(
   parameter int WIDTH     = 8,
   parameter int CCR_WIDTH = 4
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic [WIDTH-1:0]     IR,
   input  logic [CCR_WIDTH-1:0] CCR_Result,
   output logic                 IR_Load,
   output logic                 MAR_Load,
   output logic                 PC_Load,
   output logic                 PC_Inc,
   output logic                 A_Load,
   output logic                 B_Load,
   output logic                 CCR_Load,
   output logic [2:0]           ALU_Sel,
   output logic [1:0]           Bus1_Sel,
   output logic [1:0]           Bus2_Sel,
   output logic                 write,
   output logic                 halted
);

   localparam logic [1:0] BUS1_PC  = 2'b00;
   localparam logic [1:0] BUS1_A   = 2'b01;
   localparam logic [1:0] BUS1_B   = 2'b10;
   localparam logic [1:0] BUS2_ALU = 2'b00;
   localparam logic [1:0] BUS2_B1  = 2'b01;
   localparam logic [1:0] BUS2_MEM = 2'b10;
   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b010;

   typedef enum logic [4:0] {
      S_FETCH_0, S_FETCH_1, S_FETCH_2, S_DECODE,
      S_LDI_0, S_LDI_1, S_LDI_2,
      S_LDD_0, S_LDD_1, S_LDD_2, S_LDD_3, S_LDD_4,
      S_STD_0, S_STD_1, S_STD_2, S_STD_3,
      S_ALU_0,
      S_BRA_0, S_BRA_1, S_BRA_2,
      S_BEQ_SKIP,
      S_HALT
   } state_t;

   state_t state_q;
   state_t state_d;

   // IR is stable for the whole execute phase, so one path serves both A and B forms
   logic to_b_s;
   logic from_b_s;
   logic is_sub_s;

   // only Z steers the sequence; the other flags are carried for the datapath
   logic unused_ccr_s;

   logic       ir_load_s, mar_load_s, pc_load_s, pc_inc_s;
   logic       a_load_s, b_load_s, ccr_load_s, write_s, halted_s;
   logic [2:0] alu_sel_s;
   logic [1:0] bus1_sel_s, bus2_sel_s;

   assign to_b_s       = (IR == 8'h88) || (IR == 8'h89);
   assign from_b_s     = (IR == 8'h97);
   assign is_sub_s     = (IR == 8'h43);
   assign unused_ccr_s = ^{CCR_Result[3], CCR_Result[1:0]};

   // state register with synchronous reset back to the start of fetch
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= S_FETCH_0;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state sequencing; Z is consulted only in DECODE
   always_comb begin
      state_d = S_FETCH_0;
      case (state_q)
         S_FETCH_0: state_d = S_FETCH_1;
         S_FETCH_1: state_d = S_FETCH_2;
         S_FETCH_2: state_d = S_DECODE;
         S_DECODE: begin
            case (IR)
               8'h86, 8'h88: state_d = S_LDI_0;
               8'h87, 8'h89: state_d = S_LDD_0;
               8'h96, 8'h97: state_d = S_STD_0;
               8'h42, 8'h43: state_d = S_ALU_0;
               8'h20:        state_d = S_BRA_0;
               8'h23: begin
                  if (CCR_Result[2]) begin
                     state_d = S_BRA_0;
                  end else begin
                     state_d = S_BEQ_SKIP;
                  end
               end
               8'hFF:        state_d = S_HALT;
               default:      state_d = S_FETCH_0;
            endcase
         end
         S_LDI_0: state_d = S_LDI_1;
         S_LDI_1: state_d = S_LDI_2;
         S_LDD_0: state_d = S_LDD_1;
         S_LDD_1: state_d = S_LDD_2;
         S_LDD_2: state_d = S_LDD_3;
         S_LDD_3: state_d = S_LDD_4;
         S_STD_0: state_d = S_STD_1;
         S_STD_1: state_d = S_STD_2;
         S_STD_2: state_d = S_STD_3;
         S_BRA_0: state_d = S_BRA_1;
         S_BRA_1: state_d = S_BRA_2;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_FETCH_0;
      endcase
   end

   // Moore output decode; "MAR <= PC" means Bus1=PC routed through Bus2 into MAR
   always_comb begin
      ir_load_s  = 1'b0;
      mar_load_s = 1'b0;
      pc_load_s  = 1'b0;
      pc_inc_s   = 1'b0;
      a_load_s   = 1'b0;
      b_load_s   = 1'b0;
      ccr_load_s = 1'b0;
      write_s    = 1'b0;
      halted_s   = 1'b0;
      alu_sel_s  = ALU_ADD;
      bus1_sel_s = BUS1_PC;
      bus2_sel_s = BUS2_ALU;
      case (state_q)
         S_FETCH_0, S_LDI_0, S_LDD_0, S_STD_0, S_BRA_0: begin
            bus1_sel_s = BUS1_PC;
            bus2_sel_s = BUS2_B1;
            mar_load_s = 1'b1;
         end
         S_FETCH_1, S_LDI_1, S_LDD_1, S_STD_1, S_BEQ_SKIP: begin
            pc_inc_s = 1'b1;
         end
         S_FETCH_2: begin
            bus2_sel_s = BUS2_MEM;
            ir_load_s  = 1'b1;
         end
         S_LDI_2, S_LDD_4: begin
            bus2_sel_s = BUS2_MEM;
            a_load_s   = ~to_b_s;
            b_load_s   = to_b_s;
         end
         S_LDD_2, S_STD_2: begin
            bus2_sel_s = BUS2_MEM;
            mar_load_s = 1'b1;
         end
         S_STD_3: begin
            bus1_sel_s = from_b_s ? BUS1_B : BUS1_A;
            write_s    = 1'b1;
         end
         S_ALU_0: begin
            bus1_sel_s = BUS1_A;
            alu_sel_s  = is_sub_s ? ALU_SUB : ALU_ADD;
            bus2_sel_s = BUS2_ALU;
            a_load_s   = 1'b1;
            ccr_load_s = 1'b1;
         end
         S_BRA_2: begin
            bus2_sel_s = BUS2_MEM;
            pc_load_s  = 1'b1;
         end
         S_HALT: begin
            halted_s = 1'b1;
         end
         default: begin
            halted_s = 1'b0;
         end
      endcase
   end

   // Reset masks every output so an aborted instruction leaves no side effect
   always_comb begin
      if (Reset) begin
         IR_Load  = 1'b0;
         MAR_Load = 1'b0;
         PC_Load  = 1'b0;
         PC_Inc   = 1'b0;
         A_Load   = 1'b0;
         B_Load   = 1'b0;
         CCR_Load = 1'b0;
         ALU_Sel  = 3'b000;
         Bus1_Sel = 2'b00;
         Bus2_Sel = 2'b00;
         write    = 1'b0;
         halted   = 1'b0;
      end else begin
         IR_Load  = ir_load_s;
         MAR_Load = mar_load_s;
         PC_Load  = pc_load_s;
         PC_Inc   = pc_inc_s;
         A_Load   = a_load_s;
         B_Load   = b_load_s;
         CCR_Load = ccr_load_s;
         ALU_Sel  = alu_sel_s;
         Bus1_Sel = bus1_sel_s;
         Bus2_Sel = bus2_sel_s;
         write    = write_s;
         halted   = halted_s;
      end
   end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a behavioural datapath + memory model closes the loop,
// a queue holds the expected control word for every cycle of each instruction,
// and datapath state is compared after each instruction completes.
module tb_control_unit;

   logic       Clk;
   logic       Reset;
   logic [7:0] dp_ir;
   logic [3:0] dp_ccr;
   logic       IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load;
   logic [2:0] ALU_Sel;
   logic [1:0] Bus1_Sel, Bus2_Sel;
   logic       write, halted;

   control_unit #(.WIDTH(8), .CCR_WIDTH(4)) dut (
      .Clk(Clk), .Reset(Reset), .IR(dp_ir), .CCR_Result(dp_ccr),
      .IR_Load(IR_Load), .MAR_Load(MAR_Load), .PC_Load(PC_Load), .PC_Inc(PC_Inc),
      .A_Load(A_Load), .B_Load(B_Load), .CCR_Load(CCR_Load), .ALU_Sel(ALU_Sel),
      .Bus1_Sel(Bus1_Sel), .Bus2_Sel(Bus2_Sel), .write(write), .halted(halted)
   );

   // control word: IR_Load MAR_Load PC_Load PC_Inc A_Load B_Load CCR_Load ALU(3) B1(2) B2(2) write halted
   logic [15:0] dut_cw;
   assign dut_cw = {IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
                    ALU_Sel, Bus1_Sel, Bus2_Sel, write, halted};

   localparam logic [15:0] W_NONE = 16'b0_0_0_0_0_0_0_000_00_00_0_0;
   localparam logic [15:0] W_MARP = 16'b0_1_0_0_0_0_0_000_00_01_0_0;
   localparam logic [15:0] W_INC  = 16'b0_0_0_1_0_0_0_000_00_00_0_0;
   localparam logic [15:0] W_IRL  = 16'b1_0_0_0_0_0_0_000_00_10_0_0;
   localparam logic [15:0] W_MARM = 16'b0_1_0_0_0_0_0_000_00_10_0_0;
   localparam logic [15:0] W_LDAM = 16'b0_0_0_0_1_0_0_000_00_10_0_0;
   localparam logic [15:0] W_LDBM = 16'b0_0_0_0_0_1_0_000_00_10_0_0;
   localparam logic [15:0] W_STA  = 16'b0_0_0_0_0_0_0_000_01_00_1_0;
   localparam logic [15:0] W_STB  = 16'b0_0_0_0_0_0_0_000_10_00_1_0;
   localparam logic [15:0] W_ADD  = 16'b0_0_0_0_1_0_1_000_01_00_0_0;
   localparam logic [15:0] W_SUB  = 16'b0_0_0_0_1_0_1_010_01_00_0_0;
   localparam logic [15:0] W_PCLM = 16'b0_0_1_0_0_0_0_000_00_10_0_0;
   localparam logic [15:0] W_HALT = 16'b0_0_0_0_0_0_0_000_00_00_0_1;

   // ---------------- datapath + memory model ----------------
   logic [7:0] mem [0:255];
   logic [7:0] dp_pc, dp_a, dp_b, dp_mar;
   logic [7:0] wr_count, wr_addr, wr_data;
   logic       pl_req;
   logic [7:0] pl_pc, pl_a, pl_b;
   logic [3:0] pl_ccr;
   logic [7:0] bus1_s, bus2_s, alu_s;
   logic [3:0] flags_s;

   // bus, ALU and flag computation
   always_comb begin
      logic [8:0] wide;
      bus1_s = 8'h00;
      case (Bus1_Sel)
         2'b00:   bus1_s = dp_pc;
         2'b01:   bus1_s = dp_a;
         2'b10:   bus1_s = dp_b;
         default: bus1_s = 8'h00;
      endcase
      if (ALU_Sel == 3'b010) begin
         wide    = {1'b0, bus1_s} - {1'b0, dp_b};
         flags_s = {wide[7], wide[7:0] == 8'h00,
                    (bus1_s[7] != dp_b[7]) && (wide[7] != bus1_s[7]), wide[8]};
      end else begin
         wide    = {1'b0, bus1_s} + {1'b0, dp_b};
         flags_s = {wide[7], wide[7:0] == 8'h00,
                    (bus1_s[7] == dp_b[7]) && (wide[7] != bus1_s[7]), wide[8]};
      end
      alu_s  = wide[7:0];
      bus2_s = 8'h00;
      case (Bus2_Sel)
         2'b00:   bus2_s = alu_s;
         2'b01:   bus2_s = bus1_s;
         2'b10:   bus2_s = mem[dp_mar];
         default: bus2_s = 8'h00;
      endcase
   end

   // datapath registers, with a preload port for setting up each case
   always @(posedge Clk) begin
      if (pl_req) begin
         dp_pc <= pl_pc; dp_a <= pl_a; dp_b <= pl_b; dp_ccr <= pl_ccr;
         dp_ir <= 8'h00; dp_mar <= 8'h00; wr_count <= 8'h00;
         wr_addr <= 8'h00; wr_data <= 8'h00;
      end else begin
         if (IR_Load)  dp_ir  <= bus2_s;
         if (MAR_Load) dp_mar <= bus2_s;
         if (PC_Load)       dp_pc <= bus2_s;
         else if (PC_Inc)   dp_pc <= dp_pc + 8'h01;
         if (A_Load)   dp_a   <= bus2_s;
         if (B_Load)   dp_b   <= bus2_s;
         if (CCR_Load) dp_ccr <= flags_s;
         if (write) begin
            wr_count <= wr_count + 8'h01;
            wr_addr  <= dp_mar;
            wr_data  <= bus1_s;
         end
      end
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_pass   = 0;
   logic [15:0] exp_q [$];

   task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
   endtask

   // reset for two cycles while preloading the datapath model
   task automatic start_case(input logic [7:0] pc, input logic [7:0] a,
                             input logic [7:0] b, input logic [3:0] ccr);
      pl_pc = pc; pl_a = a; pl_b = b; pl_ccr = ccr;
      pl_req = 1'b1;
      Reset  = 1'b1;
      @(negedge Clk);
      check_eq("rst_out", dut_cw, W_NONE);
      step();
      pl_req = 1'b0;
      step();
      Reset = 1'b0;
   endtask

   task automatic push_fetch();
      exp_q.push_back(W_MARP);
      exp_q.push_back(W_INC);
      exp_q.push_back(W_IRL);
      exp_q.push_back(W_NONE);
   endtask

   // expected control words for one complete instruction
   task automatic push_instr(input logic [7:0] op, input logic z);
      push_fetch();
      case (op)
         8'h86, 8'h88: begin
            exp_q.push_back(W_MARP); exp_q.push_back(W_INC);
            exp_q.push_back(op == 8'h86 ? W_LDAM : W_LDBM);
         end
         8'h87, 8'h89: begin
            exp_q.push_back(W_MARP); exp_q.push_back(W_INC); exp_q.push_back(W_MARM);
            exp_q.push_back(W_NONE);
            exp_q.push_back(op == 8'h87 ? W_LDAM : W_LDBM);
         end
         8'h96, 8'h97: begin
            exp_q.push_back(W_MARP); exp_q.push_back(W_INC); exp_q.push_back(W_MARM);
            exp_q.push_back(op == 8'h96 ? W_STA : W_STB);
         end
         8'h42: exp_q.push_back(W_ADD);
         8'h43: exp_q.push_back(W_SUB);
         8'h20: begin
            exp_q.push_back(W_MARP); exp_q.push_back(W_NONE); exp_q.push_back(W_PCLM);
         end
         8'h23: begin
            if (z) begin
               exp_q.push_back(W_MARP); exp_q.push_back(W_NONE); exp_q.push_back(W_PCLM);
            end else begin
               exp_q.push_back(W_INC);
            end
         end
         default: begin
         end
      endcase
   endtask

   // compare one DUT control word per cycle until the queue is empty
   task automatic run_q();
      logic [15:0] e;
      while (exp_q.size() > 0) begin
         @(negedge Clk);
         e = exp_q.pop_front();
         check_eq("ctrl", dut_cw, e);
      end
   endtask

   initial begin
      Reset = 1'b1; pl_req = 1'b0;
      pl_pc = 8'h00; pl_a = 8'h00; pl_b = 8'h00; pl_ccr = 4'h0;

      // 1: LDA immediate
      clear_mem(); mem[0] = 8'h86; mem[1] = 8'h3C;
      start_case(8'h00, 8'h00, 8'h00, 4'h0);
      push_instr(8'h86, 1'b0); run_q(); step();
      check_eq("lda_a",  {8'h00, dp_a},     16'h003C);
      check_eq("lda_pc", {8'h00, dp_pc},    16'h0002);
      check_eq("lda_ir", {8'h00, dp_ir},    16'h0086);
      check_eq("lda_wr", {8'h00, wr_count}, 16'h0000);

      // 2: ADD, LDB immediate, SUB
      clear_mem(); mem[0] = 8'h42; mem[1] = 8'h88; mem[2] = 8'hD3; mem[3] = 8'h43;
      start_case(8'h00, 8'h18, 8'hBB, 4'h0);
      push_instr(8'h42, 1'b0); run_q(); step();
      check_eq("add_a",   {8'h00, dp_a},    16'h00D3);
      check_eq("add_ccr", {12'h000, dp_ccr}, 16'h0008);
      push_instr(8'h88, 1'b0); run_q(); step();
      check_eq("ldb_b",   {8'h00, dp_b},    16'h00D3);
      push_instr(8'h43, 1'b0); run_q(); step();
      check_eq("sub_a",   {8'h00, dp_a},    16'h0000);
      check_eq("sub_ccr", {12'h000, dp_ccr}, 16'h0004);

      // 3: STA and STB direct
      clear_mem(); mem[0] = 8'h96; mem[1] = 8'h80; mem[2] = 8'h97; mem[3] = 8'h81;
      start_case(8'h00, 8'h5A, 8'hA5, 4'h0);
      push_instr(8'h96, 1'b0); run_q(); step();
      check_eq("sta_cnt",  {8'h00, wr_count}, 16'h0001);
      check_eq("sta_addr", {8'h00, wr_addr},  16'h0080);
      check_eq("sta_data", {8'h00, wr_data},  16'h005A);
      push_instr(8'h97, 1'b0); run_q(); step();
      check_eq("stb_cnt",  {8'h00, wr_count}, 16'h0002);
      check_eq("stb_addr", {8'h00, wr_addr},  16'h0081);
      check_eq("stb_data", {8'h00, wr_data},  16'h00A5);

      // 4: BEQ taken then BRA; BEQ not taken
      clear_mem(); mem[0] = 8'h23; mem[1] = 8'h40; mem[8'h40] = 8'h20; mem[8'h41] = 8'h10;
      start_case(8'h00, 8'h00, 8'h00, 4'b0100);
      push_instr(8'h23, 1'b1); run_q(); step();
      check_eq("beq_t_pc", {8'h00, dp_pc}, 16'h0040);
      push_instr(8'h20, 1'b0); run_q(); step();
      check_eq("bra_pc",   {8'h00, dp_pc}, 16'h0010);
      clear_mem(); mem[0] = 8'h23; mem[1] = 8'h40;
      start_case(8'h00, 8'h00, 8'h00, 4'b0000);
      push_instr(8'h23, 1'b0); run_q(); step();
      check_eq("beq_n_pc", {8'h00, dp_pc}, 16'h0002);

      // 5: reset during LDA_DIR E2, then refetch (6: no-op at mem[2], HLT at mem[3])
      clear_mem(); mem[0] = 8'h87; mem[1] = 8'h50; mem[8'h50] = 8'h77; mem[3] = 8'hFF;
      start_case(8'h00, 8'h11, 8'h00, 4'h0);
      push_fetch(); exp_q.push_back(W_MARP); exp_q.push_back(W_INC);
      run_q(); step();
      Reset = 1'b1;
      @(negedge Clk);
      check_eq("rst_e2", dut_cw, W_NONE);
      step();
      Reset = 1'b0;
      check_eq("abort_a",  {8'h00, dp_a},  16'h0011);
      check_eq("abort_pc", {8'h00, dp_pc}, 16'h0002);
      push_instr(8'h00, 1'b0); run_q(); step();
      check_eq("nop_pc", {8'h00, dp_pc}, 16'h0003);
      check_eq("nop_a",  {8'h00, dp_a},  16'h0011);
      push_instr(8'hFF, 1'b0);
      for (int i = 0; i < 22; i++) exp_q.push_back(W_HALT);
      run_q(); step();
      check_eq("hlt_pc", {8'h00, dp_pc}, 16'h0004);
      Reset = 1'b1;
      @(negedge Clk);
      check_eq("hlt_rst", dut_cw, W_NONE);
      step();
      Reset = 1'b0;
      push_instr(8'h00, 1'b0); run_q(); step();
      check_eq("post_hlt_pc", {8'h00, dp_pc}, 16'h0005);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
